// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect-4 move controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package connect4_pkg;

    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;

    // Player encoding
    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    typedef logic [2:0] col_t;
    typedef logic [2:0] row_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_ISSUE   = 2'd2,
        ST_RELEASE = 2'd3
    } c4_state_t;

endpackage

// File: rtl/connect4_move_controller_if.sv
// Button/drop/status bundle between the move controller and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: drop_valid/drop_ready handshake; drop_* held while valid && !ready.
// Modports: master = move controller (drives drop_* and status), slave = buttons/board writer.
interface connect4_move_controller_if #(
    parameter int NUM_COLS = 7
);
    import connect4_pkg::*;

    logic [NUM_COLS-1:0] in_column;
    logic                new_game;
    logic                drop_ready;
    logic                drop_valid;
    col_t                drop_col;
    row_t                drop_row;
    logic                drop_player;
    logic                cur_player;
    logic                illegal_move;
    logic                board_full;

    modport master (
        input  in_column, new_game, drop_ready,
        output drop_valid, drop_col, drop_row, drop_player,
               cur_player, illegal_move, board_full
    );

    modport slave (
        output in_column, new_game, drop_ready,
        input  drop_valid, drop_col, drop_row, drop_player,
               cur_player, illegal_move, board_full
    );

endinterface

// File: rtl/column_onehot_decoder.sv
// Decodes a column button vector to a column index and flags whether exactly one bit is set.
// Latency: combinational.
// Backpressure: none.
// Ports: onehot_in (button vector), col_idx (index of set bit), onehot_ok (exactly one bit set).
module column_onehot_decoder
    import connect4_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] onehot_in,
    output col_t             col_idx,
    output logic             onehot_ok
);

    always_comb begin
        col_idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (onehot_in[k]) begin
                col_idx = col_t'(k);
            end
        end
    end

    assign onehot_ok = $onehot(onehot_in);

endmodule

// File: rtl/connect4_move_controller.sv
// Turn sequencer: validates a column press, issues one drop per legal move, alternates players.
// Latency: press on in_column -> drop_valid on the 3rd rising edge (in_q, IDLE, CHECK).
// Backpressure: drop_* held stable in ISSUE until drop_ready; state updates only on the handshake.
// Ports: clk, reset_n (async active-low), bus (master modport: buttons, new_game, drop handshake, status).
// Optional: define MOVE_TIMEOUT_EN to pass the turn after TIMEOUT_CYCLES idle cycles.
module connect4_move_controller #(
    parameter int NUM_COLS = connect4_pkg::NUM_COLS,
    parameter int NUM_ROWS = connect4_pkg::NUM_ROWS
`ifdef MOVE_TIMEOUT_EN
    , parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000
`endif
) (
    input  logic                          clk,
    input  logic                          reset_n,
    connect4_move_controller_if.master    bus
);
    import connect4_pkg::*;

    localparam logic [5:0] FULL_COUNT = 6'(NUM_COLS * NUM_ROWS);

    c4_state_t           state, state_nxt;
    logic [NUM_COLS-1:0] in_q;
    row_t                height [NUM_COLS];
    logic [5:0]          count;

    logic drop_valid_r, drop_player_r, cur_player_r, illegal_r, board_full_r;
    col_t drop_col_r;
    row_t drop_row_r;

    col_t dec_col;
    logic onehot_ok;
    logic col_full;
    logic load_drop, reject, handshake;
    logic timeout_hit;

    column_onehot_decoder #(.WIDTH(NUM_COLS)) u_dec (
        .onehot_in (in_q),
        .col_idx   (dec_col),
        .onehot_ok (onehot_ok)
    );

    assign col_full = (height[dec_col] == row_t'(NUM_ROWS));

`ifdef MOVE_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign timeout_hit = (state == ST_IDLE) && (idle_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if (bus.new_game || state != ST_IDLE || timeout_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic; new_game overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (in_q != '0 && !board_full_r) state_nxt = ST_CHECK;
            ST_CHECK:   state_nxt = (onehot_ok && !col_full) ? ST_ISSUE : ST_RELEASE;
            ST_ISSUE:   if (drop_valid_r && bus.drop_ready) state_nxt = ST_RELEASE;
            ST_RELEASE: if (in_q == '0) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if (bus.new_game) state_nxt = ST_RELEASE;
    end

    // Output/control decode
    always_comb begin
        load_drop = 1'b0;
        reject    = 1'b0;
        handshake = 1'b0;
        if (!bus.new_game) begin
            case (state)
                ST_CHECK: begin
                    if (!onehot_ok || col_full) reject    = 1'b1;
                    else                        load_drop = 1'b1;
                end
                ST_ISSUE: handshake = drop_valid_r && bus.drop_ready;
                default: ;
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q          <= '0;
            drop_valid_r  <= 1'b0;
            drop_col_r    <= '0;
            drop_row_r    <= '0;
            drop_player_r <= P1;
            cur_player_r  <= P1;
            illegal_r     <= 1'b0;
            board_full_r  <= 1'b0;
            count         <= '0;
            for (int i = 0; i < NUM_COLS; i++) height[i] <= '0;
        end else begin
            in_q      <= bus.in_column;
            illegal_r <= reject;
            if (bus.new_game) begin
                // Pending drop is discarded even if drop_ready is high this cycle
                drop_valid_r <= 1'b0;
                cur_player_r <= P1;
                board_full_r <= 1'b0;
                count        <= '0;
                for (int i = 0; i < NUM_COLS; i++) height[i] <= '0;
            end else begin
                board_full_r <= (count == FULL_COUNT);
                if (load_drop) begin
                    drop_valid_r  <= 1'b1;
                    drop_col_r    <= dec_col;
                    drop_row_r    <= height[dec_col];
                    drop_player_r <= cur_player_r;
                end
                if (handshake) begin
                    drop_valid_r       <= 1'b0;
                    height[drop_col_r] <= height[drop_col_r] + row_t'(1);
                    count              <= count + 6'd1;
                end
                if (handshake || timeout_hit) begin
                    cur_player_r <= (cur_player_r == P1) ? P2 : P1;
                end
            end
        end
    end

    assign bus.drop_valid   = drop_valid_r;
    assign bus.drop_col     = drop_col_r;
    assign bus.drop_row     = drop_row_r;
    assign bus.drop_player  = drop_player_r;
    assign bus.cur_player   = cur_player_r;
    assign bus.illegal_move = illegal_r;
    assign bus.board_full   = board_full_r;

endmodule

// File: tb/tb_connect4_move_controller.sv
// Directed bench for the Connect-4 move controller.
// Latency: n/a.
// Backpressure: exercises drop_ready held low and new_game during a pending drop.
module tb_connect4_move_controller;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    connect4_move_controller_if bus ();

    connect4_move_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_btn();
        bus.in_column = '0;
        repeat (3) tick();
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        tick();
        bus.new_game = 1'b0;
        repeat (2) tick();
    endtask

    // Press column c with drop_ready high and check the issued drop
    task automatic press_col(input int c, input int exp_row, input logic exp_pl, input string tag);
        int n;
        bus.in_column = 7'(1 << c);
        n = 0;
        while (!bus.drop_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_vld"}, 32'(bus.drop_valid), 32'd1);
        check({tag, "_col"}, 32'(bus.drop_col), 32'(c));
        check({tag, "_row"}, 32'(bus.drop_row), 32'(exp_row));
        check({tag, "_pl"},  32'(bus.drop_player), 32'(exp_pl));
        tick();
        release_btn();
    endtask

    // Hold a pattern for 6 cycles, counting illegal pulses and drops
    task automatic press_watch(input logic [6:0] pat, output int n_ill, output int n_vld);
        n_ill = 0;
        n_vld = 0;
        bus.in_column = pat;
        repeat (6) begin
            tick();
            if (bus.illegal_move) n_ill++;
            if (bus.drop_valid)   n_vld++;
        end
        release_btn();
    endtask

    initial begin
        int   n_ill, n_vld, n;
        logic [2:0] s_col, s_row;
        logic s_pl;
        logic stable;

        bus.in_column  = '0;
        bus.new_game   = 1'b0;
        bus.drop_ready = 1'b1;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_vld",  32'(bus.drop_valid), 32'd0);
        check("rst_col",  32'(bus.drop_col), 32'd0);
        check("rst_row",  32'(bus.drop_row), 32'd0);
        check("rst_pl",   32'(bus.drop_player), 32'd0);
        check("rst_cur",  32'(bus.cur_player), 32'd0);
        check("rst_ill",  32'(bus.illegal_move), 32'd0);
        check("rst_full", 32'(bus.board_full), 32'd0);

        // First move: column 2, exact latency, held button yields a single drop
        bus.in_column = 7'b0000100;
        repeat (2) tick();
        check("lat_e2_vld", 32'(bus.drop_valid), 32'd0);
        tick();
        check("lat_e3_vld", 32'(bus.drop_valid), 32'd1);
        check("m1_col", 32'(bus.drop_col), 32'd2);
        check("m1_row", 32'(bus.drop_row), 32'd0);
        check("m1_pl",  32'(bus.drop_player), 32'd0);
        tick();
        check("m1_vld_fall", 32'(bus.drop_valid), 32'd0);
        check("m1_cur", 32'(bus.cur_player), 32'd1);
        n_vld = 0;
        repeat (6) begin
            tick();
            if (bus.drop_valid) n_vld++;
        end
        check("hold_no_redrop", 32'(n_vld), 32'd0);
        release_btn();

        // Two buttons at once
        press_watch(7'b0000011, n_ill, n_vld);
        check("multi_ill_cnt", 32'(n_ill), 32'd1);
        check("multi_no_drop", 32'(n_vld), 32'd0);
        check("multi_cur",     32'(bus.cur_player), 32'd1);

        // Fill column 0 then overflow it
        pulse_new_game();
        check("ng_cur", 32'(bus.cur_player), 32'd0);
        for (int r = 0; r < 6; r++) press_col(0, r, 1'(r % 2), $sformatf("c0r%0d", r));
        press_watch(7'b0000001, n_ill, n_vld);
        check("c0_full_ill", 32'(n_ill), 32'd1);
        check("c0_full_nodrop", 32'(n_vld), 32'd0);
        check("c0_full_cur", 32'(bus.cur_player), 32'd0);

        // Backpressure: drop_ready low for 5 cycles
        pulse_new_game();
        bus.drop_ready = 1'b0;
        bus.in_column  = 7'b0001000;
        n = 0;
        while (!bus.drop_valid && n < 8) begin
            tick();
            n++;
        end
        check("bp_vld", 32'(bus.drop_valid), 32'd1);
        s_col = bus.drop_col;
        s_row = bus.drop_row;
        s_pl  = bus.drop_player;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!bus.drop_valid || bus.drop_col != s_col || bus.drop_row != s_row ||
                bus.drop_player != s_pl) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_col", 32'(bus.drop_col), 32'd3);
        check("bp_cur_wait", 32'(bus.cur_player), 32'd0);
        bus.drop_ready = 1'b1;
        tick();
        check("bp_vld_fall", 32'(bus.drop_valid), 32'd0);
        check("bp_cur_after", 32'(bus.cur_player), 32'd1);
        release_btn();
        press_col(3, 1, 1'b1, "bp_next");

        // new_game during ISSUE wins over a same-cycle ready
        pulse_new_game();
        bus.drop_ready = 1'b0;
        bus.in_column  = 7'b0000001;
        n = 0;
        while (!bus.drop_valid && n < 8) begin
            tick();
            n++;
        end
        check("ngi_vld", 32'(bus.drop_valid), 32'd1);
        bus.new_game   = 1'b1;
        bus.drop_ready = 1'b1;
        tick();
        bus.new_game = 1'b0;
        check("ngi_vld_fall", 32'(bus.drop_valid), 32'd0);
        check("ngi_cur", 32'(bus.cur_player), 32'd0);
        release_btn();
        press_col(0, 0, 1'b0, "ngi_next");

        // Fill the whole board
        pulse_new_game();
        for (int c = 0; c < 7; c++) begin
            for (int r = 0; r < 6; r++) begin
                press_col(c, r, 1'(r % 2), $sformatf("fill_c%0dr%0d", c, r));
            end
        end
        check("full_flag", 32'(bus.board_full), 32'd1);
        press_watch(7'b1000000, n_ill, n_vld);
        check("full_no_ill",  32'(n_ill), 32'd0);
        check("full_no_drop", 32'(n_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
